// File: rtl/mext_dispatch.sv
// M-extension issue stage: registers one MUL/DIV request, resolves trivial cases locally and
// otherwise hands the operands to the multiplier or divider, then holds the result for the consumer.

`ifndef MUL_OP_WIDTH
`define MUL_OP_WIDTH 2
`endif
`ifndef MUL_OP_MUL
`define MUL_OP_MUL   2'd0
`endif
`ifndef MUL_OP_MULH
`define MUL_OP_MULH  2'd1
`endif
`ifndef MUL_OP_MULSU
`define MUL_OP_MULSU 2'd2
`endif
`ifndef MUL_OP_MULU
`define MUL_OP_MULU  2'd3
`endif
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV   2'd0
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU  2'd1
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM   2'd2
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU  2'd3
`endif

module mext_dispatch #(
  parameter bit SHORTCUT_DIV  = 1'b1,
  parameter bit SHORTCUT_MUL0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_rs1,
  input  logic [31:0]               req_rs2,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      busy,
  output logic                      mul_valid,
  output logic [`MUL_OP_WIDTH-1:0]  mul_op,
  output logic [31:0]               mul_factor1,
  output logic [31:0]               mul_factor2,
  input  logic [31:0]               mul_product,
  input  logic                      mul_ready,
  output logic                      div_valid,
  output logic [`DIV_OP_WIDTH-1:0]  div_op,
  output logic [31:0]               div_dividend,
  output logic [31:0]               div_divisor,
  input  logic [31:0]               div_result,
  input  logic                      div_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [31:0]                rs1_q, rs1_d;
  logic [31:0]                rs2_q, rs2_d;
  logic [`MUL_OP_WIDTH-1:0]   mul_op_q, mul_op_d;
  logic [`DIV_OP_WIDTH-1:0]   div_op_q, div_op_d;
  logic                       mul_valid_q, mul_valid_d;
  logic                       div_valid_q, div_valid_d;
  logic [31:0]                rsp_data_q, rsp_data_d;

  logic                       is_div;
  logic                       div_zero;
  logic                       div_ovf;
  logic                       mul_zero;
  logic                       sc_hit;
  logic [31:0]                sc_data;

  // Locally resolvable cases; values match what a spec-compliant unit would return.
  always_comb begin
    is_div   = req_funct3[2];
    div_zero = (req_rs2 == 32'h0);
    div_ovf  = !req_funct3[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    mul_zero = (req_rs1 == 32'h0) || (req_rs2 == 32'h0);
    sc_hit   = 1'b0;
    sc_data  = 32'h0;
    if (is_div && SHORTCUT_DIV) begin
      if (div_zero) begin
        sc_hit  = 1'b1;
        sc_data = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
      end else if (div_ovf) begin
        sc_hit  = 1'b1;
        sc_data = req_funct3[1] ? 32'h0 : 32'h8000_0000;
      end
    end else if (!is_div && SHORTCUT_MUL0 && mul_zero) begin
      sc_hit  = 1'b1;
      sc_data = 32'h0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    mul_op_d    = mul_op_q;
    div_op_d    = div_op_q;
    mul_valid_d = mul_valid_q;
    div_valid_d = div_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          if (is_div) begin
            unique case (req_funct3[1:0])
              2'd0:    div_op_d = `DIV_OP_DIV;
              2'd1:    div_op_d = `DIV_OP_DIVU;
              2'd2:    div_op_d = `DIV_OP_REM;
              default: div_op_d = `DIV_OP_REMU;
            endcase
          end else begin
            unique case (req_funct3[1:0])
              2'd0:    mul_op_d = `MUL_OP_MUL;
              2'd1:    mul_op_d = `MUL_OP_MULH;
              2'd2:    mul_op_d = `MUL_OP_MULSU;
              default: mul_op_d = `MUL_OP_MULU;
            endcase
          end
          if (sc_hit) begin
            rsp_data_d = sc_data;
            state_d    = StResp;
          end else begin
            mul_valid_d = !is_div;
            div_valid_d = is_div;
            state_d     = StExec;
          end
        end
      end
      StExec: begin
        // A ready from the unit that was not launched is ignored.
        if (mul_valid_q && mul_ready) begin
          rsp_data_d  = mul_product;
          mul_valid_d = 1'b0;
          state_d     = StResp;
        end else if (div_valid_q && div_ready) begin
          rsp_data_d  = div_result;
          div_valid_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        mul_valid_d = 1'b0;
        div_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rs1_q       <= 32'h0;
      rs2_q       <= 32'h0;
      mul_op_q    <= '0;
      div_op_q    <= '0;
      mul_valid_q <= 1'b0;
      div_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      mul_op_q    <= mul_op_d;
      div_op_q    <= div_op_d;
      mul_valid_q <= mul_valid_d;
      div_valid_q <= div_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_data     = rsp_data_q;
  assign mul_valid    = mul_valid_q;
  assign mul_op       = mul_op_q;
  assign mul_factor1  = rs1_q;
  assign mul_factor2  = rs2_q;
  assign div_valid    = div_valid_q;
  assign div_op       = div_op_q;
  assign div_dividend = rs1_q;
  assign div_divisor  = rs2_q;

endmodule

// File: tb/tb_mext_dispatch.sv
// Randomized bench for mext_dispatch: emulated multiplier/divider with random latency and
// spurious ready pulses, results checked against RV32M arithmetic computed in the bench.

module tb_mext_dispatch;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic        mul_valid;
  logic [1:0]  mul_op;
  logic [31:0] mul_factor1;
  logic [31:0] mul_factor2;
  logic [31:0] mul_product;
  logic        mul_ready;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_result;
  logic        div_ready;

  int checks;
  int errors;
  int lat_force;

  mext_dispatch dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .mul_valid    (mul_valid),
    .mul_op       (mul_op),
    .mul_factor1  (mul_factor1),
    .mul_factor2  (mul_factor2),
    .mul_product  (mul_product),
    .mul_ready    (mul_ready),
    .div_valid    (div_valid),
    .div_op       (div_op),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_result   (div_result),
    .div_ready    (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M result of funct3 applied to a, b.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [63:0] uu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    uu = {32'h0, a} * {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: return uu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return uu[63:32];
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_shortcut(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f >= 3'd4 && b == 32'h0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (f < 3'd4 && (a == 32'h0 || b == 32'h0)) return 1'b1;
    return 1'b0;
  endfunction

  // Unit emulation: random latency, stray ready pulses while idle.
  initial begin
    bit mp, dp;
    int mcnt, dcnt;
    mp = 0; dp = 0; mcnt = 0; dcnt = 0;
    mul_ready = 1'b0; div_ready = 1'b0; mul_product = 32'h0; div_result = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mul_ready = 1'b0;
      div_ready = 1'b0;
      if (!resetn) begin
        mp = 0; dp = 0;
      end else begin
        if (mp) begin
          if (mcnt == 0) begin
            mul_ready   = 1'b1;
            mul_product = ref_result({1'b0, mul_op}, mul_factor1, mul_factor2);
            mp = 0;
          end else mcnt--;
        end else if (mul_valid) begin
          mp = 1;
          mcnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
        end else if ($urandom_range(0, 7) == 0) begin
          mul_ready   = 1'b1;
          mul_product = $urandom;
        end
        if (dp) begin
          if (dcnt == 0) begin
            div_ready  = 1'b1;
            div_result = ref_result({1'b1, div_op}, div_dividend, div_divisor);
            dp = 0;
          end else dcnt--;
        end else if (div_valid) begin
          dp = 1;
          dcnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
        end else if ($urandom_range(0, 7) == 0) begin
          div_ready  = 1'b1;
          div_result = $urandom;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic send_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output bit ok);
    int n;
    req_funct3 = f;
    req_rs1    = a;
    req_rs2    = b;
    req_valid  = 1'b1;
    n  = 0;
    ok = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready) begin
      @(negedge clk);
      ok = 1;
    end
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold);
    bit ok, saw_m, saw_d, pmr, pmv, pdr, pdv;
    int n;
    send_req(f, a, b, ok);
    if (!ok) return;
    n = 1; saw_m = 0; saw_d = 0; pmr = 0; pmv = 0; pdr = 0; pdv = 0;
    while (!rsp_valid && n < 60) begin
      saw_m |= mul_valid;
      saw_d |= div_valid;
      check({tag, "_req_ready_busy"}, req_ready, 1'b0);
      check({tag, "_one_unit"}, mul_valid & div_valid, 1'b0);
      if (pmr && pmv) check({tag, "_mul_valid_drop"}, mul_valid, 1'b0);
      if (pdr && pdv) check({tag, "_div_valid_drop"}, div_valid, 1'b0);
      pmr = mul_ready; pmv = mul_valid; pdr = div_ready; pdv = div_valid;
      @(negedge clk);
      n++;
    end
    if (pmr && pmv) check({tag, "_mul_valid_drop"}, mul_valid, 1'b0);
    if (pdr && pdv) check({tag, "_div_valid_drop"}, div_valid, 1'b0);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s_rsp_timeout: got rsp_valid=0 for 60 cycles, expected 1", tag);
      return;
    end
    if (is_shortcut(f, a, b)) begin
      check({tag, "_sc_latency"}, n, 1);
      check({tag, "_sc_no_launch"}, saw_m | saw_d, 1'b0);
    end else begin
      check({tag, "_mul_launch"}, saw_m, !f[2]);
      check({tag, "_div_launch"}, saw_d, f[2]);
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_data"}, rsp_data, exp);
      check({tag, "_hold_req_ready"}, req_ready, 1'b0);
      @(negedge clk);
    end
    check({tag, "_rsp_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, rsp_valid, 1'b0);
    check({tag, "_idle_again"}, req_ready, 1'b1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    bit ok;
    logic [2:0]  f;
    logic [31:0] a, b;
    checks = 0; errors = 0; lat_force = -1;
    resetn = 1'b0; req_valid = 1'b0; req_funct3 = 3'd0; req_rs1 = 32'h0; req_rs2 = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {mul_valid, div_valid}, 2'b00);
    check("rst_ops", {mul_op, div_op}, 4'h0);
    check("rst_operands", mul_factor1 | mul_factor2, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Hand-computed expectations pinning the arithmetic.
    do_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op("mul_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1);
    do_op("mulh_neg3x7", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 0);
    do_op("divu_by0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("remu_by0", 3'd7, 32'd100, 32'd0, 32'd100, 0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    do_op("mul_stall", 3'd0, 32'd6, 32'd7, 32'd42, 10);
    do_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    check("model_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // Reset while a multiply is in EXEC.
    lat_force = 30;
    send_req(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ok);
    repeat (2) @(negedge clk);
    check("mid_exec_mul_valid", mul_valid, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp", {31'h0, rsp_valid} | rsp_data, 32'h0);
    check("midrst_valids", {mul_valid, div_valid}, 2'b00);
    check("midrst_ops", {mul_op, div_op}, 4'h0);
    check("midrst_operands", mul_factor1 | mul_factor2, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    lat_force = -1;
    @(negedge clk);
    check("postrst_rsp_valid", rsp_valid, 1'b0);
    do_op("mul_after_rst", 3'd0, 32'd2, 32'd3, 32'd6, 0);

    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op("rand", f, a, b, ref_result(f, a, b), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2ms, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
